// File: rtl/tcp_vlg_pkg.sv
// Shared types and sequence-space helpers for the TCP transmit tracking logic.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Contents: in-flight descriptor struct, retransmit FSM state enum, and
// modulo-2^32 sequence compares (signed difference of two sequence numbers).
package tcp_vlg_pkg;

  typedef struct packed {
    logic [31:0] seq;
    logic [15:0] len;
  } tcp_rtx_desc_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    RTX   = 2'd2,
    ABORT = 2'd3
  } tcp_rtx_fsm_t;

  // a is at or after b in sequence space
  function automatic logic seq_ge(input logic [31:0] a, input logic [31:0] b);
    return $signed(a - b) >= 32'sd0;
  endfunction

  // a is strictly after b in sequence space
  function automatic logic seq_gt(input logic [31:0] a, input logic [31:0] b);
    return $signed(a - b) > 32'sd0;
  endfunction

endpackage

// File: rtl/tcp_vlg_rtx_timer.sv
// Retransmission timer: loadable down-counter plus an RTO backoff exponent.
// Latency: load/backoff take effect at the next clk edge; expired is combinational from the count.
// Backpressure: none; controls are sampled every cycle.
// Ports: clk, rst (async, active-high), clr (sync clear), load (reload count
// with the RTO in force after this cycle's backoff/reset), run (decrement
// toward zero), backoff (double RTO up to the cap), rto_rst (RTO back to base),
// expired (count is zero).
module tcp_vlg_rtx_timer #(
  parameter int unsigned RTO_TICKS     = 1000,
  parameter int unsigned RTO_MAX_SHIFT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  logic run,
  input  logic backoff,
  input  logic rto_rst,
  output logic expired
);

  localparam int unsigned TW = $clog2((RTO_TICKS << RTO_MAX_SHIFT) + 1);
  localparam int unsigned SW = $clog2(RTO_MAX_SHIFT + 2);
  localparam logic [SW-1:0] SHIFT_MAX = SW'(RTO_MAX_SHIFT);

  logic [TW-1:0] timer;
  logic [SW-1:0] shift;
  logic [SW-1:0] shift_nxt;

  // rto_rst wins over backoff so a retire in the same cycle as a
  // handshake leaves the RTO at its base value.
  always_comb begin
    shift_nxt = shift;
    if (rto_rst) begin
      shift_nxt = '0;
    end else if (backoff && (shift != SHIFT_MAX)) begin
      shift_nxt = shift + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
      shift <= '0;
    end else if (clr) begin
      timer <= '0;
      shift <= '0;
    end else begin
      shift <= shift_nxt;
      if (load) begin
        timer <= TW'(RTO_TICKS) << shift_nxt;
      end else if (run && (timer != '0)) begin
        timer <= timer - 1'b1;
      end
    end
  end

  assign expired = (timer == '0);

endmodule

// File: rtl/tcp_vlg_tx_rtx_track.sv
// In-flight segment tracker: retires on cumulative Ack, times out and requests retransmit of the oldest.
// Latency: rem_ack_val to first retire 2 cycles; timer expiry to rtx_val 1 cycle; one retire per cycle.
// Backpressure: seg_rdy low when full (unless the head retires that cycle) or aborted; rtx held until rtx_rdy.
// Ports: clk, rst (async, active-high), init (sync restart, highest priority),
// seg_val/seg_seq/seg_len/seg_rdy (new in-flight segment), rem_ack_val/rem_ack
// (remote cumulative Ack), rtx_val/rtx_seq/rtx_len/rtx_rdy (retransmit request),
// flight (bytes in flight), count (queued entries), abort (retry limit pulse).
// Optional macro TCP_VLG_TX_FAST_RTX_EN: third duplicate Ack in WAIT triggers
// an immediate retransmit of the head without RTO backoff.
module tcp_vlg_tx_rtx_track
  import tcp_vlg_pkg::*;
#(
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned RTO_TICKS     = 1000,
  parameter int unsigned RTO_MAX_SHIFT = 4,
  parameter int unsigned RETRIES       = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       init,
  input  logic                       seg_val,
  input  logic [31:0]                seg_seq,
  input  logic [15:0]                seg_len,
  output logic                       seg_rdy,
  input  logic                       rem_ack_val,
  input  logic [31:0]                rem_ack,
  output logic                       rtx_val,
  output logic [31:0]                rtx_seq,
  output logic [15:0]                rtx_len,
  input  logic                       rtx_rdy,
  output logic [31:0]                flight,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       abort
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned RW = $clog2(RETRIES + 2);

  tcp_rtx_desc_t mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  tcp_rtx_desc_t head_d;
  logic [31:0]   head_end;

  logic [31:0]   ack_q;
  logic          ack_q_vld;
  logic          ack_adv;

  tcp_rtx_fsm_t  state;
  logic [RW-1:0] retry_cnt;
  logic          fast_q;

  logic          pop;
  logic          wr;
  logic          hs;
  logic          fast_go;
  logic [CW-1:0] cnt_nxt;

  logic          tmr_load;
  logic          tmr_run;
  logic          tmr_backoff;
  logic          tmr_rto_rst;
  logic          tmr_expired;

  always_comb begin
    head_d   = mem[head];
    head_end = head_d.seq + {16'h0, head_d.len};
    ack_adv  = rem_ack_val && (!ack_q_vld || seq_gt(rem_ack, ack_q));
    // ack_q only means something once an Ack has been seen; without the
    // valid gate a segment ending at 0 would retire against the reset value.
    pop      = ack_q_vld && (count != '0) && (state != ABORT) && seq_ge(ack_q, head_end);
    // A retiring head frees its slot this cycle, so a full queue still
    // takes the new segment and count stays at DEPTH.
    seg_rdy  = (state != ABORT) && ((count < CW'(DEPTH)) || pop);
    wr       = seg_val && seg_rdy;
    cnt_nxt  = count + CW'(wr) - CW'(pop);
    hs       = (state == RTX) && rtx_rdy;
  end

  // Timer controls. Every retire restarts timing at the base RTO; a
  // duplicate-Ack retransmit handshake reloads without doubling.
  always_comb begin
    tmr_rto_rst = pop;
    tmr_backoff = hs && !fast_q;
    tmr_load    = pop || hs || ((state == IDLE) && wr);
    tmr_run     = (state == WAIT);
  end

  tcp_vlg_rtx_timer #(
    .RTO_TICKS     (RTO_TICKS),
    .RTO_MAX_SHIFT (RTO_MAX_SHIFT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (init),
    .load    (tmr_load),
    .run     (tmr_run),
    .backoff (tmr_backoff),
    .rto_rst (tmr_rto_rst),
    .expired (tmr_expired)
  );

`ifdef TCP_VLG_TX_FAST_RTX_EN
  logic [1:0] dup_cnt;
  logic       dup;

  assign dup     = rem_ack_val && ack_q_vld && (count != '0) && (rem_ack == ack_q);
  // Gated on retry budget so the timeout path remains the only way to abort.
  assign fast_go = (state == WAIT) && dup && (dup_cnt == 2'd2) && !pop &&
                   (retry_cnt < RW'(RETRIES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dup_cnt <= '0;
    end else if (init) begin
      dup_cnt <= '0;
    end else if (ack_adv || fast_go) begin
      dup_cnt <= '0;
    end else if (dup && (dup_cnt != 2'd2)) begin
      dup_cnt <= dup_cnt + 2'd1;
    end
  end
`else
  assign fast_go = 1'b0;
`endif

  // Descriptor storage carries no reset; head/tail/count define validity.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[tail] <= '{seq: seg_seq, len: seg_len};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      flight    <= '0;
      ack_q     <= '0;
      ack_q_vld <= 1'b0;
    end else if (init) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      flight    <= '0;
      ack_q     <= '0;
      ack_q_vld <= 1'b0;
    end else begin
      if (wr) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count  <= cnt_nxt;
      flight <= flight + (wr ? {16'h0, seg_len} : 32'h0) - (pop ? {16'h0, head_d.len} : 32'h0);
      if (ack_adv) begin
        ack_q     <= rem_ack;
        ack_q_vld <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rtx_val   <= 1'b0;
      rtx_seq   <= '0;
      rtx_len   <= '0;
      abort     <= 1'b0;
      retry_cnt <= '0;
      fast_q    <= 1'b0;
    end else if (init) begin
      state     <= IDLE;
      rtx_val   <= 1'b0;
      rtx_seq   <= '0;
      rtx_len   <= '0;
      abort     <= 1'b0;
      retry_cnt <= '0;
      fast_q    <= 1'b0;
    end else begin
      abort <= 1'b0;
      if (pop) begin
        retry_cnt <= '0;
      end else if (hs) begin
        retry_cnt <= retry_cnt + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (wr) state <= WAIT;
        end
        WAIT: begin
          // A retire in the same cycle as expiry wins: progress was made.
          if (cnt_nxt == '0) begin
            state <= IDLE;
          end else if (!pop && (fast_go || tmr_expired)) begin
            if (!fast_go && (retry_cnt == RW'(RETRIES))) begin
              state <= ABORT;
              abort <= 1'b1;
            end else begin
              state   <= RTX;
              rtx_val <= 1'b1;
              rtx_seq <= head_d.seq;
              rtx_len <= head_d.len;
              fast_q  <= fast_go;
            end
          end
        end
        RTX: begin
          // The request completes even if its segment retired meanwhile.
          if (hs) begin
            rtx_val <= 1'b0;
            state   <= (cnt_nxt == '0) ? IDLE : WAIT;
          end
        end
        ABORT: begin
          state <= ABORT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_vlg_tx_rtx_track.sv
module tb_tcp_vlg_tx_rtx_track;
  import tcp_vlg_pkg::*;

  localparam int unsigned DEPTH         = 8;
  localparam int unsigned RTO_TICKS     = 1000;
  localparam int unsigned RTO_MAX_SHIFT = 4;
  localparam int unsigned RETRIES       = 5;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       init;
  logic                       seg_val;
  logic [31:0]                seg_seq;
  logic [15:0]                seg_len;
  logic                       seg_rdy;
  logic                       rem_ack_val;
  logic [31:0]                rem_ack;
  logic                       rtx_val;
  logic [31:0]                rtx_seq;
  logic [15:0]                rtx_len;
  logic                       rtx_rdy;
  logic [31:0]                flight;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       abort;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int unsigned seq;
    int unsigned len;
  } mdesc_t;

  mdesc_t      mq[$];
  int unsigned m_ack;
  logic        m_ack_vld;

  tcp_vlg_tx_rtx_track #(
    .DEPTH(DEPTH), .RTO_TICKS(RTO_TICKS), .RTO_MAX_SHIFT(RTO_MAX_SHIFT), .RETRIES(RETRIES)
  ) dut (
    .clk(clk), .rst(rst), .init(init),
    .seg_val(seg_val), .seg_seq(seg_seq), .seg_len(seg_len), .seg_rdy(seg_rdy),
    .rem_ack_val(rem_ack_val), .rem_ack(rem_ack),
    .rtx_val(rtx_val), .rtx_seq(rtx_seq), .rtx_len(rtx_len), .rtx_rdy(rtx_rdy),
    .flight(flight), .count(count), .abort(abort)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init();
    init = 1'b1;
    tick();
    init = 1'b0;
  endtask

  task automatic send_seg(input logic [31:0] s, input logic [15:0] l);
    seg_val = 1'b1;
    seg_seq = s;
    seg_len = l;
    tick();
    seg_val = 1'b0;
  endtask

  task automatic send_ack(input logic [31:0] a);
    rem_ack_val = 1'b1;
    rem_ack     = a;
    tick();
    rem_ack_val = 1'b0;
  endtask

  task automatic wait_rtx(input int bound, output int n);
    n = 0;
    while (rtx_val !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
  endtask

  // RTO after k backoff doublings, capped
  function automatic int unsigned exp_rto(input int k);
    return RTO_TICKS << ((k < int'(RTO_MAX_SHIFT)) ? k : int'(RTO_MAX_SHIFT));
  endfunction

  initial begin
    int   n;
    logic held;
    logic seen;

    rst = 1'b1; init = 1'b0; seg_val = 1'b0; seg_seq = '0; seg_len = '0;
    rem_ack_val = 1'b0; rem_ack = '0; rtx_rdy = 1'b0;

    // reset state
    tick(); tick();
    chk("rst_seg_rdy", 32'(seg_rdy), 32'd1);
    chk("rst_rtx_val", 32'(rtx_val), 32'd0);
    chk("rst_rtx_seq", rtx_seq, 32'd0);
    chk("rst_rtx_len", 32'(rtx_len), 32'd0);
    chk("rst_flight", flight, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_abort", 32'(abort), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    rst = 1'b0;
    tick();

    // three segments, cumulative Ack retires two on consecutive cycles
    do_init();
    send_seg(32'd1000, 16'd100);
    send_seg(32'd1100, 16'd100);
    send_seg(32'd1200, 16'd50);
    chk("t1_count3", 32'(count), 32'd3);
    chk("t1_flight3", flight, 32'd250);
    send_ack(32'd1200);
    chk("t1_latch_nopop", 32'(count), 32'd3);
    tick();
    chk("t1_pop1_count", 32'(count), 32'd2);
    chk("t1_pop1_flight", flight, 32'd150);
    tick();
    chk("t1_pop2_count", 32'(count), 32'd1);
    chk("t1_pop2_flight", flight, 32'd50);
    tick();
    chk("t1_hold_count", 32'(count), 32'd1);
    chk("t1_state", 32'(dut.state), 32'(WAIT));

    // retire across the 2^32 wrap
    do_init();
    send_seg(32'hFFFF_FFC0, 16'd64);
    send_ack(32'h0000_0000);
    chk("t2_latch", 32'(count), 32'd1);
    tick();
    chk("t2_count", 32'(count), 32'd0);
    chk("t2_flight", flight, 32'd0);
    tick();
    chk("t2_state", 32'(dut.state), 32'(IDLE));

    // full queue, ignored write, simultaneous write+retire at full
    do_init();
    for (int i = 0; i < 8; i++) send_seg(32'd5000 + 32'(i * 10), 16'd10);
    chk("t5_count_full", 32'(count), 32'd8);
    chk("t5_rdy_full", 32'(seg_rdy), 32'd0);
    send_seg(32'd9999, 16'd77);
    chk("t5_ovf_count", 32'(count), 32'd8);
    chk("t5_ovf_flight", flight, 32'd80);
    send_ack(32'd5010);
    chk("t5_rdy_on_pop", 32'(seg_rdy), 32'd1);
    send_seg(32'd5080, 16'd30);
    chk("t5_wrpop_count", 32'(count), 32'd8);
    chk("t5_wrpop_flight", flight, 32'd100);
    send_ack(32'd5110);
    repeat (8) tick();
    chk("t5_drain_count", 32'(count), 32'd0);
    chk("t5_drain_flight", flight, 32'd0);

    // randomized queue traffic against a queue model (too short for a timeout)
    do_init();
    mq.delete();
    m_ack = 0;
    m_ack_vld = 1'b0;
    begin
      int unsigned nseq;
      nseq = 32'hFFFF_F000;
      for (int c = 0; c < 400; c++) begin
        int unsigned lo, span, sum;
        logic m_pop, m_rdy, m_wr;
        seg_val = ($urandom_range(0, 2) != 0);
        seg_seq = nseq;
        seg_len = 16'($urandom_range(1, 200));
        lo = ((mq.size() > 0) ? mq[0].seq : nseq) - 64;
        span = nseq - lo;
        rem_ack_val = ($urandom_range(0, 3) == 0);
        rem_ack = lo + $urandom_range(0, span);
        m_pop = m_ack_vld && (mq.size() > 0) && (int'(m_ack - (mq[0].seq + mq[0].len)) >= 0);
        m_rdy = (mq.size() < int'(DEPTH)) || m_pop;
        chk("rnd_rdy", 32'(seg_rdy), 32'(m_rdy));
        m_wr = seg_val && m_rdy;
        tick();
        if (m_pop) void'(mq.pop_front());
        if (m_wr) begin
          mq.push_back('{seq: seg_seq, len: 32'(seg_len)});
          nseq = nseq + 32'(seg_len);
        end
        if (rem_ack_val && (!m_ack_vld || int'(rem_ack - m_ack) > 0)) begin
          m_ack = rem_ack;
          m_ack_vld = 1'b1;
        end
        sum = 0;
        foreach (mq[i]) sum += mq[i].len;
        chk("rnd_count", 32'(count), 32'(mq.size()));
        chk("rnd_flight", flight, sum);
      end
      seg_val = 1'b0;
      rem_ack_val = 1'b0;
    end

    // duplicate Acks
    do_init();
    send_seg(32'd1000, 16'd100);
    send_ack(32'd1000);
    repeat (3) send_ack(32'd1000);
`ifdef TCP_VLG_TX_FAST_RTX_EN
    chk("fast_rtx_val", 32'(rtx_val), 32'd1);
    chk("fast_rtx_seq", rtx_seq, 32'd1000);
    rtx_rdy = 1'b1;
    tick();
    rtx_rdy = 1'b0;
    wait_rtx(int'(RTO_TICKS) + 100, n);
    chk("fast_rto_same", 32'(n), 32'(RTO_TICKS + 1));
`else
    seen = rtx_val;
    for (int i = 0; i < 30; i++) begin
      tick();
      seen = seen | rtx_val;
    end
    chk("no_fast_rtx", 32'(seen), 32'd0);
`endif

    // timeout, hold without rtx_rdy, exponential backoff, abort
    do_init();
    send_seg(32'd1000, 16'd100);
    for (int k = 0; k < int'(RETRIES); k++) begin
      wait_rtx(int'(exp_rto(k)) + 100, n);
      chk($sformatf("rtx_lat%0d", k), 32'(n), exp_rto(k) + 1);
      chk($sformatf("rtx_seq%0d", k), rtx_seq, 32'd1000);
      chk($sformatf("rtx_len%0d", k), 32'(rtx_len), 32'd100);
      if (k == 0) begin
        held = 1'b1;
        for (int h = 0; h < 5; h++) begin
          tick();
          held = held && rtx_val && (rtx_seq == 32'd1000) && (rtx_len == 16'd100);
        end
        chk("rtx_hold", 32'(held), 32'd1);
      end
      rtx_rdy = 1'b1;
      tick();
      rtx_rdy = 1'b0;
      chk($sformatf("rtx_drop%0d", k), 32'(rtx_val), 32'd0);
    end
    n = 0;
    seen = 1'b0;
    while (abort !== 1'b1 && n < int'(exp_rto(RETRIES)) + 100) begin
      tick();
      n++;
      seen = seen | rtx_val;
    end
    chk("abort_lat", 32'(n), exp_rto(RETRIES) + 1);
    chk("abort_no_rtx", 32'(seen), 32'd0);
    chk("abort_seg_rdy", 32'(seg_rdy), 32'd0);
    tick();
    chk("abort_pulse", 32'(abort), 32'd0);
    send_seg(32'd2000, 16'd10);
    chk("abort_wr_count", 32'(count), 32'd1);
    chk("abort_wr_flight", flight, 32'd100);
    repeat (3) tick();
    chk("abort_stay_rdy", 32'(seg_rdy), 32'd0);
    chk("abort_stay_state", 32'(dut.state), 32'(ABORT));
    do_init();
    chk("init_seg_rdy", 32'(seg_rdy), 32'd1);
    chk("init_count", 32'(count), 32'd0);
    chk("init_state", 32'(dut.state), 32'(IDLE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
